// File: rtl/axi_pkg.sv
// Shared AXI constants and the write-slave state type.
// Used by the write responder (axi_write_slave) and the read responder.
package axi_pkg;

  // AxBURST encodings
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  // xRESP encodings
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  // AxSIZE encoding for a 4-byte beat
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;

  // Write-slave FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DATA = 2'b01,
    RESP = 2'b10
  } wslave_state_e;

endpackage

// File: rtl/axi_wslave_mem.sv
// Byte-enable word RAM backing the write slave.
// Ports: clk; we/waddr/wdata/wstrb synchronous write; raddr -> rdata_c
// combinational read. Contents are never reset.
module axi_wslave_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata_c
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Per-byte write; a zero strobe leaves the word untouched
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/axi_write_slave.sv
// AXI4 write-channel responder: one burst at a time over AW/W/B, data
// committed into a byte-enabled word memory.
// Ports: clk, rst (async, active-high); AW channel (AWADDR, AWVALID,
// AWREADY, AWLEN, AWSIZE, AWBURST); W channel (WDATA, WSTRB, WLAST,
// WVALID, WREADY); B channel (BRESP, BVALID, BREADY); dbg_addr/dbg_rdata
// combinational side read of the memory.
module axi_write_slave
  import axi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH          = 32,
  parameter int unsigned WRITE_CHANNEL_WIDTH = 32,
  parameter int unsigned WRITE_BURST_LEN     = 8,
  parameter int unsigned MEM_DEPTH           = 256
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            AWADDR,
  input  logic                             AWVALID,
  output logic                             AWREADY,
  input  logic [WRITE_BURST_LEN-1:0]       AWLEN,
  input  logic [2:0]                       AWSIZE,
  input  logic [1:0]                       AWBURST,
  input  logic [WRITE_CHANNEL_WIDTH-1:0]   WDATA,
  input  logic [WRITE_CHANNEL_WIDTH/8-1:0] WSTRB,
  input  logic                             WLAST,
  input  logic                             WVALID,
  output logic                             WREADY,
  output logic [1:0]                       BRESP,
  output logic                             BVALID,
  input  logic                             BREADY,
  input  logic [$clog2(MEM_DEPTH)-1:0]     dbg_addr,
  output logic [WRITE_CHANNEL_WIDTH-1:0]   dbg_rdata
);

  localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
  localparam int unsigned MEM_AW = $clog2(MEM_DEPTH);

  wslave_state_e              state_q, state_d;
  logic [IDX_W-1:0]           widx_q, widx_d;
  logic [WRITE_BURST_LEN-1:0] len_q, len_d;
  logic [WRITE_BURST_LEN-1:0] beat_cnt_q, beat_cnt_d;
  logic                       incr_q, incr_d;
  logic                       aw_err_q, aw_err_d;
  logic [1:0]                 resp_q, resp_d;

  logic             aw_hs, w_hs, b_hs, last_beat, aw_err, mem_we;
  logic [IDX_W:0]   aw_last_idx;

  assign aw_hs     = AWVALID && AWREADY;
  assign w_hs      = WVALID && WREADY;
  assign b_hs      = BVALID && BREADY;
  assign last_beat = (beat_cnt_q == len_q);
  assign mem_we    = w_hs && !aw_err_q;

  // Burst legality; last index computed one bit wider so it cannot wrap
  always_comb begin
    aw_last_idx = {1'b0, AWADDR[ADDR_WIDTH-1:2]};
    if (AWBURST == AXI_BURST_INCR) aw_last_idx = aw_last_idx + (IDX_W+1)'(AWLEN);
    aw_err = (AWSIZE != AXI_SIZE_4B)
          || ((AWBURST != AXI_BURST_FIXED) && (AWBURST != AXI_BURST_INCR))
          || (AWADDR[1:0] != 2'b00)
          || (aw_last_idx >= (IDX_W+1)'(MEM_DEPTH));
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    incr_d     = incr_q;
    aw_err_d   = aw_err_q;
    resp_d     = resp_q;
    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          widx_d     = AWADDR[ADDR_WIDTH-1:2];
          len_d      = AWLEN;
          incr_d     = (AWBURST == AXI_BURST_INCR);
          aw_err_d   = aw_err;
          resp_d     = aw_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          // WLAST only affects the response; termination follows beat_cnt
          if (WLAST != last_beat) resp_d = AXI_RESP_SLVERR;
          if (last_beat) begin
            state_d = RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + WRITE_BURST_LEN'(1);
            if (incr_q) widx_d = widx_q + IDX_W'(1);
          end
        end
      end
      RESP: begin
        if (b_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      widx_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      incr_q     <= 1'b0;
      aw_err_q   <= 1'b0;
      resp_q     <= AXI_RESP_OKAY;
      AWREADY    <= 1'b1;
      WREADY     <= 1'b0;
      BVALID     <= 1'b0;
      BRESP      <= AXI_RESP_OKAY;
    end else begin
      state_q    <= state_d;
      widx_q     <= widx_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      incr_q     <= incr_d;
      aw_err_q   <= aw_err_d;
      resp_q     <= resp_d;
      AWREADY    <= (state_d == IDLE);
      WREADY     <= (state_d == DATA);
      BVALID     <= (state_d == RESP);
      BRESP      <= resp_d;
    end
  end

  axi_wslave_mem #(
    .DATA_W (WRITE_CHANNEL_WIDTH),
    .DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (widx_q[MEM_AW-1:0]),
    .wdata   (WDATA),
    .wstrb   (WSTRB),
    .raddr   (dbg_addr),
    .rdata_c (dbg_rdata)
  );

endmodule

// File: tb/tb_axi_write_slave.sv
// Self-checking bench for axi_write_slave: directed cases plus randomized
// bursts against a word-array reference memory.
module tb_axi_write_slave;

  localparam int DEPTH = 256;

  logic        clk, rst;
  logic [31:0] AWADDR;
  logic        AWVALID, AWREADY;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_rdata;

  axi_write_slave dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] bdata [256];
  logic [3:0]  bstrb [256];

  // Current burst as seen by the model
  longint cur_start;
  int      cur_len, cur_bad_wlast;
  bit      cur_incr, cur_err, cur_wlast_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit burst_err(input logic [31:0] addr, input int len,
                                   input logic [2:0] size, input logic [1:0] burst);
    longint start, last;
    start = longint'(addr / 4);
    last  = (burst == 2'b01) ? start + len : start;
    return (size != 3'b010) || (burst > 2'b01) || (addr % 4 != 0) || (last >= DEPTH);
  endfunction

  task automatic drive_w(input int b);
    WVALID = 1'b1;
    WDATA  = bdata[b];
    WSTRB  = bstrb[b];
    WLAST  = (b == cur_len) ^ (b == cur_bad_wlast);
  endtask

  task automatic do_aw(input logic [31:0] addr, input int len, input logic [2:0] size,
                       input logic [1:0] burst, input int bad_wlast, input bit early_w);
    int n;
    cur_start     = longint'(addr / 4);
    cur_len       = len;
    cur_incr      = (burst == 2'b01);
    cur_err       = burst_err(addr, len, size, burst);
    cur_bad_wlast = bad_wlast;
    cur_wlast_err = 1'b0;
    AWADDR = addr; AWLEN = 8'(len); AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    if (early_w) begin
      drive_w(0);
      chk("early_w_wready", 32'(WREADY), 32'd0);
    end
    n = 0;
    while (!AWREADY && n < 50) begin @(posedge clk); #1; n++; end
    chk("aw_wait_timeout", 32'(n >= 50), 32'd0);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    chk("aw_then_wready", 32'(WREADY), 32'd1);
    chk("aw_then_awready", 32'(AWREADY), 32'd0);
  endtask

  task automatic do_beat(input int b, input bit gaps);
    int n;
    longint idx;
    if (gaps && b > 0 && ($urandom % 4 == 0)) begin
      WVALID = 1'b0; @(posedge clk); #1;
    end
    drive_w(b);
    n = 0;
    while (!WREADY && n < 50) begin @(posedge clk); #1; n++; end
    chk("w_wait_timeout", 32'(n >= 50), 32'd0);
    @(posedge clk); #1;
    if (!cur_err) begin
      idx = cur_incr ? cur_start + b : cur_start;
      for (int k = 0; k < 4; k++)
        if (bstrb[b][k]) ref_mem[int'(idx)][8*k +: 8] = bdata[b][8*k +: 8];
    end
    if (b == cur_bad_wlast) cur_wlast_err = 1'b1;
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic do_b(input int bdelay);
    logic [1:0] exp;
    exp = (cur_err || cur_wlast_err) ? 2'b10 : 2'b00;
    chk("bvalid_after_last", 32'(BVALID), 32'd1);
    chk("bresp", 32'(BRESP), 32'(exp));
    chk("wready_in_resp", 32'(WREADY), 32'd0);
    for (int i = 0; i < bdelay; i++) begin
      @(posedge clk); #1;
      chk("b_hold_bvalid", 32'(BVALID), 32'd1);
      chk("b_hold_bresp", 32'(BRESP), 32'(exp));
      chk("b_hold_awready", 32'(AWREADY), 32'd0);
    end
    BREADY = 1'b1;
    @(posedge clk); #1;
    BREADY = 1'b0;
    chk("b_done_bvalid", 32'(BVALID), 32'd0);
    chk("b_done_awready", 32'(AWREADY), 32'd1);
  endtask

  task automatic mem_cmp(input string tag);
    int nbad, first;
    logic [31:0] fg, fe;
    nbad = 0; first = -1; fg = '0; fe = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = 8'(i); #1;
      if (dbg_rdata !== ref_mem[i]) begin
        if (first < 0) begin first = i; fg = dbg_rdata; fe = ref_mem[i]; end
        nbad++;
      end
    end
    checks++;
    assert (nbad == 0) else begin
      failures++;
      $error("FAIL mem_%s: %0d words differ, first word %0d observed=%h expected=%h",
             tag, nbad, first, fg, fe);
    end
    @(posedge clk); #1;
  endtask

  task automatic rd(input int idx, output logic [31:0] v);
    dbg_addr = 8'(idx); #1;
    v = dbg_rdata;
  endtask

  task automatic run_burst(input string tag, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int bad_wlast, input int bdelay, input bit early_w,
                           input bit gaps);
    do_aw(addr, len, size, burst, bad_wlast, early_w);
    for (int b = 0; b <= len; b++) do_beat(b, gaps);
    do_b(bdelay);
    mem_cmp(tag);
  endtask

  task automatic rand_data(input int len);
    for (int b = 0; b <= len; b++) begin bdata[b] = $urandom; bstrb[b] = 4'hF; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    rst = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = 2'b01;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0; dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_awready", 32'(AWREADY), 32'd1);
    chk("reset_wready", 32'(WREADY), 32'd0);
    chk("reset_bvalid", 32'(BVALID), 32'd0);
    chk("reset_bresp", 32'(BRESP), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_awready", 32'(AWREADY), 32'd1);

    // Fill the whole memory with a maximal 256-beat INCR burst
    rand_data(255);
    run_burst("fill", 32'h0, 255, 3'b010, 2'b01, -1, 0, 1'b0, 1'b0);

    // INCR 0x10 x4
    for (int b = 0; b < 4; b++) begin bdata[b] = 32'hA0 + b; bstrb[b] = 4'hF; end
    run_burst("incr", 32'h10, 3, 3'b010, 2'b01, -1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rd(4 + i, v);
      chk("incr_word", v, 32'hA0 + i);
    end
    @(posedge clk); #1;

    // FIXED 0x20 x2
    bdata[0] = 32'h1111_1111; bdata[1] = 32'h2222_2222; bstrb[0] = 4'hF; bstrb[1] = 4'hF;
    run_burst("fixed", 32'h20, 1, 3'b010, 2'b00, -1, 1, 1'b0, 1'b0);
    rd(8, v);
    chk("fixed_word8", v, 32'h2222_2222);
    @(posedge clk); #1;

    // Byte strobes on word 9
    bdata[0] = 32'hFFFF_FFFF; bstrb[0] = 4'hF;
    run_burst("strb_pre", 32'h24, 0, 3'b010, 2'b01, -1, 0, 1'b0, 1'b0);
    bdata[0] = 32'h1234_5678; bstrb[0] = 4'b0101;
    run_burst("strb", 32'h24, 0, 3'b010, 2'b01, -1, 0, 1'b0, 1'b0);
    rd(9, v);
    chk("strb_word9", v, 32'hFF34_FF78);
    @(posedge clk); #1;

    // Zero strobe still counts as a beat
    bdata[0] = $urandom; bstrb[0] = 4'h0;
    run_burst("strb_zero", 32'h24, 0, 3'b010, 2'b01, -1, 0, 1'b0, 1'b0);

    // Error bursts: range, size, burst code, alignment, high-address wrap
    rand_data(1);
    run_burst("err_range", 32'h3FC, 1, 3'b010, 2'b01, -1, 0, 1'b0, 1'b0);
    rand_data(0);
    run_burst("err_size", 32'h40, 0, 3'b001, 2'b01, -1, 0, 1'b0, 1'b0);
    rand_data(0);
    run_burst("err_burst", 32'h40, 0, 3'b010, 2'b10, -1, 0, 1'b0, 1'b0);
    rand_data(0);
    run_burst("err_align", 32'h42, 0, 3'b010, 2'b01, -1, 0, 1'b0, 1'b0);
    rand_data(15);
    run_burst("err_wrap", 32'hFFFF_FFF0, 15, 3'b010, 2'b01, -1, 0, 1'b0, 1'b0);
    rand_data(0);
    run_burst("err_fixed_hi", 32'h400, 0, 3'b010, 2'b00, -1, 0, 1'b0, 1'b0);
    // Last legal word is fine
    rand_data(1);
    run_burst("edge_ok", 32'h3F8, 1, 3'b010, 2'b01, -1, 0, 1'b0, 1'b0);

    // Early WLAST with a 5-cycle BREADY stall
    rand_data(1);
    run_burst("wlast_early", 32'h80, 1, 3'b010, 2'b01, 0, 5, 1'b0, 1'b0);

    // W presented together with AW
    rand_data(0);
    run_burst("early_w", 32'h100, 0, 3'b010, 2'b01, -1, 0, 1'b1, 1'b0);

    // Reset during beat 2 of a 4-beat burst
    rand_data(3);
    do_aw(32'hC0, 3, 3'b010, 2'b01, -1, 1'b0);
    do_beat(0, 1'b0);
    do_beat(1, 1'b0);
    drive_w(2);
    rst = 1'b1;
    #1;
    chk("rst_async_awready", 32'(AWREADY), 32'd1);
    chk("rst_async_wready", 32'(WREADY), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
    chk("rst_next_awready", 32'(AWREADY), 32'd1);
    chk("rst_next_wready", 32'(WREADY), 32'd0);
    chk("rst_next_bvalid", 32'(BVALID), 32'd0);
    mem_cmp("rst_partial");
    rand_data(0);
    run_burst("after_rst", 32'hC8, 0, 3'b010, 2'b01, -1, 0, 1'b0, 1'b0);

    // Randomized bursts
    for (int r = 0; r < 40; r++) begin
      int idx, len, badw;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [1:0]  burst;
      idx  = $urandom_range(0, 255);
      len  = ($urandom % 8 == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7);
      addr = 32'(idx * 4);
      if ($urandom % 10 == 0) addr[1:0] = 2'($urandom_range(1, 3));
      size  = ($urandom % 10 == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      burst = ($urandom % 10 == 0) ? 2'($urandom_range(0, 3))
                                   : (($urandom % 3 == 0) ? 2'b00 : 2'b01);
      badw  = ($urandom % 8 == 0) ? $urandom_range(0, len) : -1;
      for (int b = 0; b <= len; b++) begin bdata[b] = $urandom; bstrb[b] = 4'($urandom); end
      run_burst("rand", addr, len, size, burst, badw, $urandom_range(0, 3),
                1'($urandom % 4 == 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_write_slave.md
# axi_write_slave

AXI4 write-channel responder: accepts one write burst at a time on the AW, W and B channels and commits the data into a byte-enabled word memory. It is the write-direction counterpart of the existing `axi_slave` read responder. It sits on the same `clk` domain as `axi_master` and is driven by the write path of the master or by a bench. A side read port exposes memory contents for checking.

## Interface
- ADDR_WIDTH, 32, width of AWADDR (byte address)
- WRITE_CHANNEL_WIDTH, 32, width of WDATA; WSTRB is WRITE_CHANNEL_WIDTH/8
- WRITE_BURST_LEN, 8, width of AWLEN
- MEM_DEPTH, 256, number of words in the backing memory (power of two)

Ports:
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  asynchronous, active-high reset
- AWADDR  in  ADDR_WIDTH  burst start byte address
- AWVALID  in  1  address valid
- AWREADY  out  1  address ready
- AWLEN  in  WRITE_BURST_LEN  beats minus 1
- AWSIZE  in  3  beat size; only 3'b010 (4 bytes) is supported
- AWBURST  in  2  00 FIXED, 01 INCR; all other codes are unsupported
- WDATA  in  WRITE_CHANNEL_WIDTH  write data
- WSTRB  in  WRITE_CHANNEL_WIDTH/8  byte enables
- WLAST  in  1  last beat marker
- WVALID  in  1  data valid
- WREADY  out  1  data ready
- BRESP  out  2  00 OKAY, 10 SLVERR
- BVALID  out  1  response valid
- BREADY  in  1  response ready
- dbg_addr  in  $clog2(MEM_DEPTH)  word index for side read
- dbg_rdata  out  WRITE_CHANNEL_WIDTH  combinational memory read at dbg_addr

## Operation
- The FSM has three states.
  - IDLE: AWREADY=1. On AWVALID&&AWREADY, latch addr, len, burst and the error flag, clear beat_cnt, then go to DATA.
  - DATA: WREADY=1. Each WVALID&&WREADY is one accepted beat. On the beat where beat_cnt==len, go to RESP; otherwise beat_cnt increments.
  - RESP: BVALID=1, BRESP=latched response. On BVALID&&BREADY, go to IDLE.
- Word index is addr[ADDR_WIDTH-1:2]. For INCR it increments by 1 per beat; for FIXED it is unchanged.
- The burst error flag is set at AW time if any of these holds:
  - AWSIZE != 3'b010
  - AWBURST is not 00 or 01
  - AWADDR[1:0] != 0
  - the last word index (start+len for INCR, start for FIXED) is >= MEM_DEPTH
- For an errored burst, all len+1 beats are still accepted, no memory write occurs, and BRESP=SLVERR.
- The memory write is synchronous on an accepted beat. Each byte i is written only where WSTRB[i]=1; WSTRB=0 writes nothing but still counts as a beat.
- WLAST check: WLAST must equal (beat_cnt==len) on every accepted beat. Any mismatch sets the response to SLVERR; earlier writes in that burst remain committed. Burst termination uses only beat_cnt and ignores WLAST.
- Address width arithmetic: the word index register is ADDR_WIDTH-2 bits wide. The range check is done at full width, so no wrap-around into low memory occurs.

## Timing
- Reset values: state=IDLE, AWREADY=1, WREADY=0, BVALID=0, BRESP=00. Memory contents are not reset.
- Reset asserted mid-burst returns the block to IDLE immediately. Beats already written stay written, and no B response is issued.
- AW handshake in cycle N gives WREADY=1 from N+1. A W beat presented with or before AW is not accepted until then.
- Final beat accepted in cycle M gives BVALID=1 from M+1.
- BVALID and BRESP are held stable until BREADY. A B handshake in cycle K gives AWREADY=1 from K+1.
- Minimum burst of 1 beat takes 3 cycles (AW, W, B), and outstanding bursts are limited to 1.
- WREADY and AWREADY are never high in the same cycle.
- dbg_rdata reflects a write on the cycle after the write edge.

## Structure
- Shared package `axi_pkg` holds:
  - burst codes AXI_BURST_FIXED and AXI_BURST_INCR
  - response codes AXI_RESP_OKAY and AXI_RESP_SLVERR
  - the size code AXI_SIZE_4B
  - the write-slave state enum (IDLE, DATA, RESP)

  The read slave uses the same constants.
- Sub-module `axi_wslave_mem` is a MEM_DEPTH x WRITE_CHANNEL_WIDTH byte-enable RAM with one synchronous write port and one combinational read port. The FSM, counters and checks live in the top level.

## Test plan
- INCR burst with AWADDR=0x10, AWLEN=3, data 0xA0..0xA3, full WSTRB, BREADY held high → words 4..7 hold 0xA0..0xA3, BRESP=OKAY, BVALID the cycle after the 4th beat.
- FIXED burst with AWADDR=0x20, AWLEN=1, data 0x11111111 then 0x22222222 → word 8 = 0x22222222, BRESP=OKAY.
- Byte strobes: word 9 preloaded with 0xFFFFFFFF, then a single beat 0x12345678 with WSTRB=4'b0101 → word 9 = 0xFF34FF78.
- Error cases, each with memory unchanged and BRESP=SLVERR:
  - AWADDR=0x3FC with AWLEN=1 (out of range)
  - AWSIZE=3'b001
  - AWBURST=2'b10
- WLAST asserted on beat 0 of an AWLEN=1 burst → both beats written, BRESP=SLVERR. Hold BREADY low 5 cycles → BVALID and BRESP stable, AWREADY=0 until the cycle after BREADY.
- rst pulsed during beat 2 of a 4-beat burst → next cycle AWREADY=1, WREADY=0, BVALID=0. A new 1-beat burst afterwards completes with OKAY.
